// File: rtl/warp_scoreboard_pkg.sv
// Shared definitions for the warp register scoreboard: address-width helper,
// the hard-wired zero register and the packing of per-slot register fields.
package warp_scoreboard_pkg;

    localparam int X0 = 0;

    function automatic int addr_w(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    // Slot k's field lives in bits [k*rw +: rw] of each packed slot vector.
    function automatic int field_lsb(input int slot, input int rw);
        return slot * rw;
    endfunction

endpackage

// File: rtl/warp_scoreboard_cnt.sv
// One register's in-flight write counter: net increment/decrement per cycle,
// clamped at 0 and CMAX, with a same-cycle error strobe on under/overflow.
module warp_scoreboard_cnt #(
    parameter int CNT_W = 2,
    parameter int INC_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [INC_W-1:0] i_inc,
    input  logic [DEC_W-1:0] i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);

    localparam int CMAX = (1 << CNT_W) - 1;

    int               sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        sum     = int'(o_cnt) + int'(i_inc) - int'(i_dec);
        cnt_nxt = sum[CNT_W-1:0];
        o_err   = 1'b0;
        if (i_flush) begin
            cnt_nxt = '0;
        end else if (sum < 0) begin
            cnt_nxt = '0;
            o_err   = 1'b1;
        end else if (sum > CMAX) begin
            cnt_nxt = CMAX[CNT_W-1:0];
            o_err   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_cnt <= '0;
        else          o_cnt <= cnt_nxt;
    end

endmodule

// File: rtl/warp_scoreboard.sv
// Issue-stage register scoreboard: per-register in-flight write counters with
// in-order combinational slot readiness and writeback retirement.
module warp_scoreboard import warp_scoreboard_pkg::*; #(
    parameter int  NREGS     = 32,
    parameter int  ISSUE_W   = 2,
    parameter int  WB_W      = 2,
    parameter int  CNT_W     = 2,
    parameter bit  ALLOW_WAW = 1'b0,
    parameter bit  WB_BYPASS = 1'b0,
    localparam int RW        = addr_w(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ISSUE_W-1:0]    i_slot_valid,
    input  logic [ISSUE_W*RW-1:0] i_slot_rs1,
    input  logic [ISSUE_W*RW-1:0] i_slot_rs2,
    input  logic [ISSUE_W*RW-1:0] i_slot_rd,
    input  logic [ISSUE_W-1:0]    i_slot_rd_we,
    input  logic [ISSUE_W-1:0]    i_issue_fire,
    input  logic [WB_W-1:0]       i_wb_valid,
    input  logic [WB_W*RW-1:0]    i_wb_rd,
    input  logic                  i_flush,
    output logic [ISSUE_W-1:0]    o_slot_ready,
    output logic [NREGS-1:0]      o_busy,
    output logic                  o_idle,
    output logic                  o_err
);

    localparam int INC_W = $clog2(ISSUE_W + 1);
    localparam int DEC_W = $clog2(WB_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic [RW-1:0]    rs1   [ISSUE_W];
    logic [RW-1:0]    rs2   [ISSUE_W];
    logic [RW-1:0]    rd    [ISSUE_W];
    logic [RW-1:0]    wb_rd [WB_W];
    logic [CNT_W-1:0] cnt   [NREGS];
    logic [INC_W-1:0] inc   [1:NREGS-1];
    logic [DEC_W-1:0] dec   [1:NREGS-1];
    logic [NREGS-1:1] cnt_err;
    logic [NREGS-1:0] pend;
    logic             prefix_ok;
    logic             ok;
    int               same_rd;
    int               eff;
    logic             fire_bad;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            rs1[k] = i_slot_rs1[field_lsb(k, RW) +: RW];
            rs2[k] = i_slot_rs2[field_lsb(k, RW) +: RW];
            rd[k]  = i_slot_rd[field_lsb(k, RW) +: RW];
        end
        for (int p = 0; p < WB_W; p++)
            wb_rd[p] = i_wb_rd[field_lsb(p, RW) +: RW];
    end

    // Per-register tallies; x0 is excluded by starting at register 1.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            inc[r] = '0;
            dec[r] = '0;
            for (int k = 0; k < ISSUE_W; k++)
                if (i_issue_fire[k] && i_slot_rd_we[k] && rd[k] == RW'(r))
                    inc[r] = inc[r] + INC_W'(1);
            for (int p = 0; p < WB_W; p++)
                if (i_wb_valid[p] && wb_rd[p] == RW'(r))
                    dec[r] = dec[r] + DEC_W'(1);
        end
    end

    always_comb begin
        pend = '0;
        eff  = 0;
        for (int r = 1; r < NREGS; r++) begin
            eff     = int'(cnt[r]) - (WB_BYPASS ? int'(dec[r]) : 0);
            pend[r] = (eff != 0);
        end
    end

    always_comb begin
        o_slot_ready = '0;
        prefix_ok    = 1'b1;
        ok           = 1'b0;
        same_rd      = 0;
        for (int k = 0; k < ISSUE_W; k++) begin
            ok      = i_slot_valid[k] && prefix_ok && !pend[rs1[k]] && !pend[rs2[k]];
            same_rd = 0;
            for (int j = 0; j < k; j++) begin
                if (i_slot_rd_we[j] && rd[j] != RW'(X0)) begin
                    if (rd[j] == rs1[k] || rd[j] == rs2[k]) ok = 1'b0;
                    if (i_slot_rd_we[k] && rd[j] == rd[k]) same_rd = same_rd + 1;
                end
            end
            if (i_slot_rd_we[k] && rd[k] != RW'(X0)) begin
                if (ALLOW_WAW) begin
                    if (int'(cnt[rd[k]]) + same_rd >= CMAX) ok = 1'b0;
                end else if (pend[rd[k]] || same_rd != 0) begin
                    ok = 1'b0;
                end
            end
            o_slot_ready[k] = ok;
            prefix_ok       = ok;
        end
    end

    // Fires must be ready and form a contiguous prefix starting at slot 0.
    always_comb begin
        fire_bad = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (i_issue_fire[k] && !o_slot_ready[k]) fire_bad = 1'b1;
            if (k > 0 && i_issue_fire[k] && !i_issue_fire[k-1]) fire_bad = 1'b1;
        end
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        warp_scoreboard_cnt #(
            .CNT_W (CNT_W),
            .INC_W (INC_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_flush (i_flush),
            .i_inc   (inc[r]),
            .i_dec   (dec[r]),
            .o_cnt   (cnt[r]),
            .o_err   (cnt_err[r])
        );
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) o_busy[r] = (cnt[r] != '0);
    end

    assign o_idle = ~|o_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                   o_err <= 1'b0;
        else if (!i_flush && (fire_bad || |cnt_err))    o_err <= 1'b1;
    end

endmodule

// File: tb/tb_warp_scoreboard.sv
// Bench for warp_scoreboard: instance 0 is strict (no WAW, no bypass), instance 1
// allows WAW with writeback bypass; both are checked against a counter-array model.
module tb_warp_scoreboard;

    localparam int NR   = 32;
    localparam int RW   = 5;
    localparam int IW   = 2;
    localparam int WW   = 2;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [IW-1:0] valid [2];
    logic [IW-1:0] we    [2];
    logic [IW-1:0] fire  [2];
    logic [WW-1:0] wbv   [2];
    logic          flush [2];
    logic [RW-1:0] rs1   [2][IW];
    logic [RW-1:0] rs2   [2][IW];
    logic [RW-1:0] rd    [2][IW];
    logic [RW-1:0] wbrd  [2][WW];

    logic [IW-1:0] rdy0, rdy1;
    logic [NR-1:0] busy0, busy1;
    logic          idle0, idle1, err0, err1;

    int            m_cnt   [2][NR];
    bit            m_err   [2];
    logic [IW-1:0] exp_rdy [2];
    logic [IW-1:0] last_rdy[2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    warp_scoreboard #(.NREGS(NR), .ISSUE_W(IW), .WB_W(WW), .CNT_W(CW),
                      .ALLOW_WAW(1'b0), .WB_BYPASS(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_slot_valid(valid[0]),
        .i_slot_rs1({rs1[0][1], rs1[0][0]}), .i_slot_rs2({rs2[0][1], rs2[0][0]}),
        .i_slot_rd({rd[0][1], rd[0][0]}), .i_slot_rd_we(we[0]), .i_issue_fire(fire[0]),
        .i_wb_valid(wbv[0]), .i_wb_rd({wbrd[0][1], wbrd[0][0]}), .i_flush(flush[0]),
        .o_slot_ready(rdy0), .o_busy(busy0), .o_idle(idle0), .o_err(err0));

    warp_scoreboard #(.NREGS(NR), .ISSUE_W(IW), .WB_W(WW), .CNT_W(CW),
                      .ALLOW_WAW(1'b1), .WB_BYPASS(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_slot_valid(valid[1]),
        .i_slot_rs1({rs1[1][1], rs1[1][0]}), .i_slot_rs2({rs2[1][1], rs2[1][0]}),
        .i_slot_rd({rd[1][1], rd[1][0]}), .i_slot_rd_we(we[1]), .i_issue_fire(fire[1]),
        .i_wb_valid(wbv[1]), .i_wb_rd({wbrd[1][1], wbrd[1][0]}), .i_flush(flush[1]),
        .o_slot_ready(rdy1), .o_busy(busy1), .o_idle(idle1), .o_err(err1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [NR-1:0] get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_idle(input int d);
        return (d == 0) ? idle0 : idle1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic int wb_to(input int d, input int r);
        int n = 0;
        for (int p = 0; p < WW; p++)
            if (wbv[d][p] && int'(wbrd[d][p]) == r) n++;
        return n;
    endfunction

    function automatic bit pending(input int d, input int r);
        if (r == 0) return 1'b0;
        return (m_cnt[d][r] - ((d == 1) ? wb_to(d, r) : 0)) != 0;
    endfunction

    // Instance 1 is the WAW + bypass configuration.
    function automatic logic [IW-1:0] model_ready(input int d);
        logic [IW-1:0] res = '0;
        bit prev = 1'b1;
        for (int k = 0; k < IW; k++) begin
            bit ok = valid[d][k] && prev;
            int earlier = 0;
            if (pending(d, int'(rs1[d][k])) || pending(d, int'(rs2[d][k]))) ok = 1'b0;
            for (int j = 0; j < k; j++) begin
                if (we[d][j] && rd[d][j] != 0) begin
                    if (rd[d][j] == rs1[d][k] || rd[d][j] == rs2[d][k]) ok = 1'b0;
                    if (we[d][k] && rd[d][j] == rd[d][k]) earlier++;
                end
            end
            if (we[d][k] && rd[d][k] != 0) begin
                if (d == 1) begin
                    if (m_cnt[d][rd[d][k]] + earlier >= CMAX) ok = 1'b0;
                end else if (pending(d, int'(rd[d][k])) || earlier > 0) begin
                    ok = 1'b0;
                end
            end
            res[k] = ok;
            prev   = ok;
        end
        return res;
    endfunction

    task automatic model_clock(input int d);
        bit viol = 1'b0;
        int nxt;
        if (flush[d]) begin
            for (int r = 0; r < NR; r++) m_cnt[d][r] = 0;
            return;
        end
        for (int k = 0; k < IW; k++) begin
            if (fire[d][k] && !exp_rdy[d][k]) viol = 1'b1;
            if (k > 0 && fire[d][k] && !fire[d][k-1]) viol = 1'b1;
        end
        for (int r = 1; r < NR; r++) begin
            nxt = m_cnt[d][r] - wb_to(d, r);
            for (int k = 0; k < IW; k++)
                if (fire[d][k] && we[d][k] && int'(rd[d][k]) == r) nxt++;
            if (nxt < 0) begin
                nxt = 0;
                viol = 1'b1;
            end else if (nxt > CMAX) begin
                nxt = CMAX;
                viol = 1'b1;
            end
            m_cnt[d][r] = nxt;
        end
        if (viol) m_err[d] = 1'b1;
    endtask

    task automatic clear_stim();
        for (int d = 0; d < 2; d++) begin
            valid[d] = '0; we[d] = '0; fire[d] = '0; wbv[d] = '0; flush[d] = 1'b0;
            for (int k = 0; k < IW; k++) begin
                rs1[d][k] = '0; rs2[d][k] = '0; rd[d][k] = '0;
            end
            for (int p = 0; p < WW; p++) wbrd[d][p] = '0;
        end
    endtask

    task automatic set_slot(input int d, input int k, input int a, input int b,
                            input int dst, input bit wr);
        valid[d][k] = 1'b1;
        rs1[d][k]   = RW'(a);
        rs2[d][k]   = RW'(b);
        rd[d][k]    = RW'(dst);
        we[d][k]    = wr;
    endtask

    task automatic set_wb(input int d, input int p, input int r);
        wbv[d][p]  = 1'b1;
        wbrd[d][p] = RW'(r);
    endtask

    // fmode 0: random legal prefix, 1: fire everything ready, 2: fire f0/f1 as given.
    task automatic cycle(input int fmode, input logic [IW-1:0] f0, input logic [IW-1:0] f1);
        logic [NR-1:0] eb;
        #2;
        for (int d = 0; d < 2; d++) begin
            int n, m;
            exp_rdy[d]  = model_ready(d);
            last_rdy[d] = get_rdy(d);
            chk($sformatf("ready%0d", d), 32'(last_rdy[d]), 32'(exp_rdy[d]));
            case (fmode)
                0: begin
                    n = exp_rdy[d][0] ? (exp_rdy[d][1] ? 2 : 1) : 0;
                    m = $urandom_range(n, 0);
                    fire[d] = IW'((1 << m) - 1);
                end
                1: fire[d] = exp_rdy[d];
                default: fire[d] = (d == 0) ? f0 : f1;
            endcase
        end
        @(posedge clk);
        model_clock(0);
        model_clock(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            eb = '0;
            for (int r = 0; r < NR; r++) eb[r] = (m_cnt[d][r] != 0);
            chk($sformatf("busy%0d", d), 32'(get_busy(d)), 32'(eb));
            chk($sformatf("idle%0d", d), 32'(get_idle(d)), 32'(eb == '0));
            chk($sformatf("err%0d", d), 32'(get_err(d)), 32'(m_err[d]));
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            for (int r = 0; r < NR; r++) m_cnt[d][r] = 0;
        end
    endtask

    task automatic rand_stim();
        int tmp [NR];
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NR; r++) tmp[r] = m_cnt[d][r];
            for (int k = 0; k < IW; k++) begin
                valid[d][k] = ($urandom % 4) != 0;
                rs1[d][k]   = RW'($urandom_range(7, 0));
                rs2[d][k]   = RW'($urandom_range(7, 0));
                rd[d][k]    = RW'($urandom_range(7, 0));
                we[d][k]    = $urandom % 2;
            end
            for (int p = 0; p < WW; p++) begin
                int r = $urandom_range(7, 1);
                wbv[d][p]  = 1'b0;
                wbrd[d][p] = RW'(r);
                if (($urandom % 2) != 0 && tmp[r] > 0) begin
                    wbv[d][p] = 1'b1;
                    tmp[r]--;
                end
            end
            flush[d] = ($urandom % 32) == 0;
        end
    endtask

    initial begin
        clear_stim();
        reset_model();
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", 32'(get_busy(d)), 32'h0);
            chk("reset_idle", 32'(get_idle(d)), 32'h1);
            chk("reset_err",  32'(get_err(d)),  32'h0);
            chk("reset_rdy",  32'(get_rdy(d)),  32'h0);
        end
        @(negedge clk) rst_n = 1'b1;

        // add x5 <- x1,x2 then a reader of x5 blocks until writeback
        set_slot(0, 0, 1, 2, 5, 1'b1);
        cycle(1, '0, '0);
        chk("t1_rdy", 32'(last_rdy[0]), 32'h1);
        chk("t1_busy5", 32'(busy0[5]), 32'h1);
        clear_stim(); set_slot(0, 0, 5, 0, 0, 1'b0);
        cycle(2, '0, '0);
        chk("t1_raw_stall", 32'(last_rdy[0]), 32'h0);
        clear_stim(); set_wb(0, 0, 5);
        cycle(1, '0, '0);
        chk("t1_idle", 32'(idle0), 32'h1);
        clear_stim(); set_slot(0, 0, 5, 0, 0, 1'b0);
        cycle(2, '0, '0);
        chk("t1_rdy_after_wb", 32'(last_rdy[0]), 32'h1);

        // intra-bundle RAW, then independent pair
        clear_stim(); set_slot(0, 0, 1, 2, 7, 1'b1); set_slot(0, 1, 7, 0, 10, 1'b0);
        cycle(2, '0, '0);
        chk("t2_bundle_raw", 32'(last_rdy[0]), 32'h1);
        clear_stim(); set_slot(0, 0, 1, 2, 7, 1'b1); set_slot(0, 1, 1, 0, 8, 1'b1);
        cycle(1, '0, '0);
        chk("t2_rdy11", 32'(last_rdy[0]), 32'h3);
        chk("t2_busy7_8", 32'({busy0[8], busy0[7]}), 32'h3);
        clear_stim(); set_wb(0, 0, 7); set_wb(0, 1, 8);
        cycle(1, '0, '0);

        // writeback bypass: only instance 1 sees x3 free in the retiring cycle
        clear_stim(); set_slot(0, 0, 0, 0, 3, 1'b1); set_slot(1, 0, 0, 0, 3, 1'b1);
        cycle(1, '0, '0);
        clear_stim(); set_slot(0, 0, 3, 0, 0, 1'b0); set_slot(1, 0, 3, 0, 0, 1'b0);
        set_wb(0, 0, 3); set_wb(1, 0, 3);
        cycle(1, '0, '0);
        chk("t3_bypass", 32'(last_rdy[1]), 32'h1);
        chk("t3_nobypass", 32'(last_rdy[0]), 32'h0);

        // WAW up to saturation on instance 1
        for (int i = 0; i < 3; i++) begin
            clear_stim(); set_slot(1, 0, 0, 0, 9, 1'b1);
            cycle(1, '0, '0);
        end
        chk("t4_busy9", 32'(busy1[9]), 32'h1);
        clear_stim(); set_slot(1, 0, 0, 0, 9, 1'b1);
        cycle(2, '0, '0);
        chk("t4_sat_stall", 32'(last_rdy[1]), 32'h0);
        clear_stim(); set_wb(1, 0, 9);
        cycle(1, '0, '0);
        clear_stim(); set_slot(1, 0, 0, 0, 9, 1'b1);
        cycle(2, '0, '0);
        chk("t4_ready_after_wb", 32'(last_rdy[1]), 32'h1);
        clear_stim(); set_wb(1, 0, 9); set_wb(1, 1, 9);
        cycle(1, '0, '0);

        // in-order prefix and x0 handling
        clear_stim(); set_slot(0, 0, 0, 0, 4, 1'b1);
        cycle(1, '0, '0);
        clear_stim(); set_slot(0, 0, 4, 0, 0, 1'b0); set_slot(0, 1, 1, 0, 11, 1'b1);
        cycle(2, '0, '0);
        chk("t5_prefix", 32'(last_rdy[0]), 32'h0);
        clear_stim(); set_slot(0, 0, 0, 0, 0, 1'b1); set_slot(0, 1, 0, 0, 0, 1'b1);
        cycle(1, '0, '0);
        chk("t5_x0_rdy", 32'(last_rdy[0]), 32'h3);
        chk("t5_x0_busy", 32'(busy0[0]), 32'h0);
        clear_stim(); set_wb(0, 0, 4);
        cycle(1, '0, '0);

        // flush drops everything and masks errors; a stale writeback afterwards is an error
        clear_stim(); set_slot(0, 0, 0, 0, 2, 1'b1); set_slot(0, 1, 0, 0, 6, 1'b1);
        cycle(1, '0, '0);
        clear_stim(); flush[0] = 1'b1; set_wb(0, 0, 2); set_slot(0, 0, 0, 0, 2, 1'b1);
        cycle(2, 2'b01, '0);
        chk("t6_flush_busy", 32'(busy0), 32'h0);
        chk("t6_flush_err", 32'(err0), 32'h0);
        clear_stim(); set_wb(0, 0, 6);
        cycle(1, '0, '0);
        chk("t6_stale_wb_err", 32'(err0), 32'h1);
        clear_stim();
        cycle(1, '0, '0);
        chk("t6_err_sticky", 32'(err0), 32'h1);

        // firing an invalid slot is a protocol error but still reserves rd
        clear_stim(); rd[1][0] = RW'(12); we[1][0] = 1'b1;
        cycle(2, '0, 2'b01);
        chk("t7_bad_fire_err", 32'(err1), 32'h1);
        chk("t7_bad_fire_busy", 32'(busy1[12]), 32'h1);
        clear_stim(); set_wb(1, 0, 12);
        cycle(1, '0, '0);

        for (int i = 0; i < 400; i++) begin
            rand_stim();
            cycle(0, '0, '0);
        end

        // asynchronous reset in the middle of traffic
        clear_stim(); set_slot(0, 0, 0, 0, 13, 1'b1); set_slot(1, 0, 0, 0, 13, 1'b1);
        cycle(1, '0, '0);
        clear_stim();
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        for (int d = 0; d < 2; d++) begin
            chk("midreset_busy", 32'(get_busy(d)), 32'h0);
            chk("midreset_idle", 32'(get_idle(d)), 32'h1);
            chk("midreset_err",  32'(get_err(d)),  32'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        cycle(1, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/warp_scoreboard.md
Name: warp_scoreboard

Overview:
- Parametrised register scoreboard for the issue stage. Generalises the single-bit reservation register to per-register in-flight write counters.
- Supports N issue slots and M writeback ports, with optional writeback bypass and optional multiple outstanding writes (WAW).
- Sits between decode/issue bundle selection and the execution units. Issue consults it combinationally; writeback retires reservations.

Parameters:
- NREGS, 32, number of architectural integer registers; address width RW = clog2(NREGS).
- ISSUE_W, 2, issue slots checked per cycle, in program order (slot 0 oldest).
- WB_W, 2, writeback ports retiring reservations per cycle.
- CNT_W, 2, width of per-register in-flight counter; saturation value CMAX = 2^CNT_W-1.
- ALLOW_WAW, 0, 1 = a pending rd does not stall while its counter is below CMAX; 0 = any pending rd stalls.
- WB_BYPASS, 0, 1 = same-cycle writebacks are subtracted before the readiness check.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_slot_valid  in  ISSUE_W  slot holds an instruction
- i_slot_rs1  in  ISSUE_W*RW  source 1 address per slot
- i_slot_rs2  in  ISSUE_W*RW  source 2 address per slot
- i_slot_rd  in  ISSUE_W*RW  destination address per slot
- i_slot_rd_we  in  ISSUE_W  slot writes rd
- i_issue_fire  in  ISSUE_W  slot dispatched this cycle
- i_wb_valid  in  WB_W  writeback retiring a reservation
- i_wb_rd  in  WB_W*RW  retiring destination
- i_flush  in  1  clear all reservations
- o_slot_ready  out  ISSUE_W  slot free of hazards (combinational)
- o_busy  out  NREGS  per-register counter non-zero (registered)
- o_idle  out  1  no reservation outstanding (registered)
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async, i_rst_n low): all counters 0, o_busy 0, o_idle 1, o_err 0. Reset mid-operation drops all reservations immediately.
- Register 0 is never reserved, never checked and never decremented. Slot or writeback references to x0 are ignored.
- Effective count eff[r] = cnt[r] - (WB_BYPASS ? number of valid wb to r this cycle : 0).
- pend(r) = eff[r] != 0.
- o_slot_ready[k] requires all of:
  - i_slot_valid[k];
  - o_slot_ready[j] for all j<k (in-order prefix);
  - !pend(rs1), !pend(rs2);
  - if rd_we: ALLOW_WAW ? cnt[rd] + earlier same-rd issues < CMAX : !pend(rd);
  - no earlier slot j<k with rd_we, rd≠0 and rd equal to rs1/rs2 of k (intra-bundle RAW);
  - if ALLOW_WAW=0, no earlier slot writing the same rd (intra-bundle WAW).
- i_issue_fire must be a subset of o_slot_ready and a contiguous prefix. A violation sets o_err and the fired slot is still counted.
- Next count: cnt' = cnt + (#fire with rd_we to r) - (#wb to r). Update visible on o_busy/o_slot_ready the cycle after.
- Simultaneous issue and wb to the same register apply net. A wb to a register with cnt + same-cycle issues = 0 sets o_err, and the counter stays 0 (no wrap).
- Overflow cannot occur when ready is obeyed. Any forced overflow sets o_err and the counter saturates at CMAX.
- i_flush: all counters become 0 next cycle; same-cycle fires and wbs are ignored and do not set o_err. The backend suppresses writebacks of squashed instructions.
- o_idle = all counters 0 (registered alongside counters).

Decomposition:
- Shared defines header: RW derivation helper, the x0 constant, the slot field packing order (rs1 [RW-1:0] per slot index).
- One natural sub-module: warp_scoreboard_cnt. It holds one register's counter with inc-count/dec-count inputs, saturation and error flag, generated NREGS-1 times.
- Slot hazard logic stays in the top module.

Test Plan:
- Reset, slot0 add x5<-x1,x2 valid -> ready=01. Fire. Next cycle o_busy[5]=1. Slot0 reading x5 -> ready=0. Wb x5 -> following cycle ready=1, o_idle=1.
- Bundle slot0 writes x7, slot1 reads x7 -> ready=01. Slot1 reads x8 instead -> ready=11, both fire, o_busy[7]=o_busy[8]=1.
- WB_BYPASS=1: x3 busy, wb x3 same cycle as slot0 reading x3 -> ready=01. With WB_BYPASS=0 -> ready=00.
- ALLOW_WAW=1, CNT_W=2: fire three writes to x9 over three cycles -> cnt=3. Fourth write to x9 -> not ready. One wb -> ready next cycle.
- Slot0 blocked on busy x4, slot1 independent -> ready=00 (in-order prefix). Rd/rs=x0 with no pending -> never stalls, o_busy[0] stays 0.
- Flush with x2, x6 busy and a same-cycle wb to x2 -> all counters 0 next cycle, o_err=0. A later wb to x6 -> o_err=1 sticky until reset.
